// File: rtl/relu_maxpool_layer_if.sv
// Pixel stream from the conv stage into the pooling layer, and pooled pixel
// stream with row RAM write address out to the next layer.
interface relu_maxpool_layer_if;
  logic        frame_start;
  logic        in_de;
  logic [20:0] in_ch0;
  logic [20:0] in_ch1;
  logic [20:0] in_ch2;
  logic        out_de;
  logic [23:0] out_data;
  logic [10:0] out_addr;
  logic [10:0] out_row;
  logic        row_done;
  logic        frame_done;

  modport master (
    output frame_start, in_de, in_ch0, in_ch1, in_ch2,
    input  out_de, out_data, out_addr, out_row, row_done, frame_done
  );

  modport slave (
    input  frame_start, in_de, in_ch0, in_ch1, in_ch2,
    output out_de, out_data, out_addr, out_row, row_done, frame_done
  );
endinterface

// File: rtl/relu_maxpool_layer.sv
// ReLU + shift/saturate requantization of three conv channels followed by
// 2x2 stride-2 max pooling, emitting packed pixels for the next layer's row RAMs.
module relu_maxpool_layer #(
  parameter int IN_WIDTH  = 26,
  parameter int IN_HEIGHT = 26,
  parameter int SHIFT     = 5,
  parameter int bit_depth = 8
) (
  input  logic                clk,
  input  logic                RESET,
  relu_maxpool_layer_if.slave bus
);
  localparam int PW    = IN_WIDTH / 2;
  localparam int PH    = IN_HEIGHT / 2;
  localparam int LB_AW = (PW > 1) ? $clog2(PW) : 1;
  localparam int QMAX  = (1 << bit_depth) - 1;

  localparam logic [10:0] COL_LAST  = 11'(IN_WIDTH - 1);
  localparam logic [10:0] ROW_LAST  = 11'(IN_HEIGHT - 1);
  localparam logic [10:0] COL_LIM   = 11'(PW * 2);
  localparam logic [10:0] ROW_LIM   = 11'(PH * 2);
  localparam logic [10:0] ADDR_LAST = 11'(PW - 1);
  localparam logic [10:0] OROW_LAST = 11'(PH - 1);

  function automatic logic [7:0] quant(input logic [20:0] x);
    logic [20:0] v;
    v = x[20] ? 21'd0 : (x >> SHIFT);
    quant = (v > 21'(QMAX)) ? 8'(QMAX) : v[7:0];
  endfunction

  function automatic logic [23:0] max_px(input logic [23:0] a, input logic [23:0] b);
    logic [23:0] m;
    m = '0;
    for (int k = 0; k < 3; k++)
      m[k*8 +: 8] = (a[k*8 +: 8] > b[k*8 +: 8]) ? a[k*8 +: 8] : b[k*8 +: 8];
    max_px = m;
  endfunction

  logic [10:0]      col, row;
  logic             accept, in_use;
  logic             s1_de;
  logic [10:0]      s1_col, s1_row;
  logic [23:0]      s1_q;
  logic [23:0]      hreg, h;
  logic [23:0]      lb [PW];
  logic [LB_AW-1:0] lb_idx;
  logic             de_q, row_done_q, frame_done_q;
  logic [23:0]      data_q;
  logic [10:0]      addr_q, orow_q;

  assign accept = bus.in_de && !bus.frame_start;
  // Trailing odd column/row still advance the counters but never enter pooling.
  assign in_use = (col < COL_LIM) && (row < ROW_LIM);
  assign h      = max_px(hreg, s1_q);
  assign lb_idx = LB_AW'(s1_col >> 1);

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      col <= '0;
      row <= '0;
    end else if (bus.frame_start) begin
      col <= '0;
      row <= '0;
    end else if (bus.in_de) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? 11'd0 : row + 11'd1;
      end else begin
        col <= col + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      s1_de  <= 1'b0;
      s1_col <= '0;
      s1_row <= '0;
      s1_q   <= '0;
    end else if (bus.frame_start) begin
      s1_de  <= 1'b0;
      s1_col <= '0;
      s1_row <= '0;
      s1_q   <= '0;
    end else begin
      s1_de <= accept && in_use;
      if (accept) begin
        s1_col <= col;
        s1_row <= row;
        s1_q   <= {quant(bus.in_ch0), quant(bus.in_ch1), quant(bus.in_ch2)};
      end
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      hreg         <= '0;
      for (int i = 0; i < PW; i++) lb[i] <= '0;
      de_q         <= 1'b0;
      data_q       <= '0;
      addr_q       <= '0;
      orow_q       <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (bus.frame_start) begin
      hreg         <= '0;
      for (int i = 0; i < PW; i++) lb[i] <= '0;
      de_q         <= 1'b0;
      data_q       <= '0;
      addr_q       <= '0;
      orow_q       <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      de_q         <= 1'b0;
      row_done_q   <= de_q && (addr_q == ADDR_LAST);
      frame_done_q <= de_q && (addr_q == ADDR_LAST) && (orow_q == OROW_LAST);
      if (s1_de) begin
        if (!s1_col[0]) begin
          hreg <= s1_q;
        end else if (!s1_row[0]) begin
          lb[lb_idx] <= h;
        end else begin
          de_q   <= 1'b1;
          data_q <= max_px(lb[lb_idx], h);
          addr_q <= s1_col >> 1;
          orow_q <= s1_row >> 1;
        end
      end
    end
  end

  assign bus.out_de     = de_q;
  assign bus.out_data   = data_q;
  assign bus.out_addr   = addr_q;
  assign bus.out_row    = orow_q;
  assign bus.row_done   = row_done_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_relu_maxpool_layer.sv
// Directed bench: three instances (4x4 shift 0, default 26x26 shift 5, 5x5 shift 0)
// share one stimulus stream; each phase resets and checks one instance.
module tb_relu_maxpool_layer;
  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        frame_start = 1'b0;
  logic        in_de = 1'b0;
  logic [20:0] ch0 = '0, ch1 = '0, ch2 = '0;
  int          cyc = 0;
  int          checks = 0, errors = 0;
  int          last_in_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  relu_maxpool_layer_if if_a ();
  relu_maxpool_layer_if if_b ();
  relu_maxpool_layer_if if_c ();

  assign if_a.frame_start = frame_start;
  assign if_a.in_de = in_de;
  assign if_a.in_ch0 = ch0;
  assign if_a.in_ch1 = ch1;
  assign if_a.in_ch2 = ch2;
  assign if_b.frame_start = frame_start;
  assign if_b.in_de = in_de;
  assign if_b.in_ch0 = ch0;
  assign if_b.in_ch1 = ch1;
  assign if_b.in_ch2 = ch2;
  assign if_c.frame_start = frame_start;
  assign if_c.in_de = in_de;
  assign if_c.in_ch0 = ch0;
  assign if_c.in_ch1 = ch1;
  assign if_c.in_ch2 = ch2;

  relu_maxpool_layer #(.IN_WIDTH(4), .IN_HEIGHT(4), .SHIFT(0), .bit_depth(8))
    dut_a (.clk(clk), .RESET(RESET), .bus(if_a));
  relu_maxpool_layer #(.IN_WIDTH(26), .IN_HEIGHT(26), .SHIFT(5), .bit_depth(8))
    dut_b (.clk(clk), .RESET(RESET), .bus(if_b));
  relu_maxpool_layer #(.IN_WIDTH(5), .IN_HEIGHT(5), .SHIFT(0), .bit_depth(8))
    dut_c (.clk(clk), .RESET(RESET), .bus(if_c));

  logic [23:0] res_a [256], res_b [256], res_c [256];
  int de_a, rd_a, fd_a, de_b, rd_b, fd_b, de_c, rd_c, fd_c;
  int last_de_a, fd_cyc_a, last_de_b, fd_cyc_b, rd_cyc_b;
  int q_de_a [$], q_in_a [$];

  always @(negedge clk) begin
    if (if_a.out_de) begin
      if (int'(if_a.out_row) * 2 + int'(if_a.out_addr) < 256)
        res_a[int'(if_a.out_row) * 2 + int'(if_a.out_addr)] = if_a.out_data;
      de_a++;
      last_de_a = cyc;
      q_de_a.push_back(cyc);
    end
    if (if_a.row_done) rd_a++;
    if (if_a.frame_done) begin fd_a++; fd_cyc_a = cyc; end
    if (if_b.out_de) begin
      if (int'(if_b.out_row) * 13 + int'(if_b.out_addr) < 256)
        res_b[int'(if_b.out_row) * 13 + int'(if_b.out_addr)] = if_b.out_data;
      de_b++;
      last_de_b = cyc;
    end
    if (if_b.row_done) begin rd_b++; rd_cyc_b = cyc; end
    if (if_b.frame_done) begin fd_b++; fd_cyc_b = cyc; end
    if (if_c.out_de) begin
      if (int'(if_c.out_row) * 2 + int'(if_c.out_addr) < 256)
        res_c[int'(if_c.out_row) * 2 + int'(if_c.out_addr)] = if_c.out_data;
      de_c++;
    end
    if (if_c.row_done) rd_c++;
    if (if_c.frame_done) fd_c++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 256; i++) begin
      res_a[i] = 'x; res_b[i] = 'x; res_c[i] = 'x;
    end
    de_a = 0; rd_a = 0; fd_a = 0; de_b = 0; rd_b = 0; fd_b = 0;
    de_c = 0; rd_c = 0; fd_c = 0;
    last_de_a = -1; fd_cyc_a = -1; last_de_b = -1; fd_cyc_b = -1; rd_cyc_b = -1;
    q_de_a.delete(); q_in_a.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    RESET = 1'b0; frame_start = 1'b0; in_de = 1'b0;
    ch0 = '0; ch1 = '0; ch2 = '0;
    idle(1);
    RESET = 1'b1;
    clear_mon();
  endtask

  task automatic send(input int v0, input int v1, input int v2, input int gap);
    in_de = 1'b1; ch0 = 21'(v0); ch1 = 21'(v1); ch2 = 21'(v2);
    last_in_cyc = cyc;
    idle(1);
    in_de = 1'b0;
    idle(gap);
  endtask

  function automatic int pat(input int r, input int c, input int k);
    return ((r * 37 + c * 101 + k * 53 + r * c * 7) % 10000) - 1000;
  endfunction

  function automatic int qm(input int x);
    if (x < 0) return 0;
    return (x / 32 > 255) ? 255 : x / 32;
  endfunction

  function automatic logic [23:0] exp_b(input int pr, input int pc);
    logic [23:0] e;
    int m, q;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      m = 0;
      for (int d = 0; d < 4; d++) begin
        q = qm(pat(2 * pr + d / 2, 2 * pc + d % 2, k));
        if (q > m) m = q;
      end
      e[23 - 8 * k -: 8] = 8'(m);
    end
    return e;
  endfunction

  task automatic feed_b(input int n, input int gap_max);
    for (int i = 0; i < n; i++)
      send(pat(i / 26, i % 26, 0), pat(i / 26, i % 26, 1), pat(i / 26, i % 26, 2),
           int'($urandom_range(gap_max, 0)));
  endtask

  task automatic check_frame_b(input string tag);
    check_val({tag, " de_count"}, de_b, 169);
    check_val({tag, " row_done_count"}, rd_b, 13);
    check_val({tag, " frame_done_count"}, fd_b, 1);
    check_val({tag, " frame_done_timing"}, fd_cyc_b, last_de_b + 1);
    check_val({tag, " frame_done_with_row_done"}, fd_cyc_b, rd_cyc_b);
    for (int r = 0; r < 13; r++)
      for (int c = 0; c < 13; c++)
        check_val($sformatf("%s px_%0d_%0d", tag, r, c), res_b[r * 13 + c], exp_b(r, c));
  endtask

  int p3_ch1 [12] = '{-1, 6885, -1000, -1000, -1, 6885, 8191, 8192, -1000, -1000, -5, 100};

  initial begin
    clear_mon();
    idle(2);
    RESET = 1'b0;
    idle(1);
    check_val("rst out_de", if_b.out_de, 0);
    check_val("rst out_data", if_b.out_data, 0);
    check_val("rst out_addr", if_b.out_addr, 0);
    check_val("rst out_row", if_b.out_row, 0);
    check_val("rst row_done", if_b.row_done, 0);
    check_val("rst frame_done", if_b.frame_done, 0);
    RESET = 1'b1;

    // Ramp on the 4x4 instance
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        send(r * 4 + c, 0, 0, 0);
        if (r % 2 == 1 && c % 2 == 1) q_in_a.push_back(last_in_cyc);
      end
    idle(5);
    check_val("ramp de_count", de_a, 4);
    check_val("ramp px00", res_a[0], 24'h050000);
    check_val("ramp px01", res_a[1], 24'h070000);
    check_val("ramp px10", res_a[2], 24'h0D0000);
    check_val("ramp px11", res_a[3], 24'h0F0000);
    check_val("ramp lat_count", q_de_a.size(), q_in_a.size());
    for (int i = 0; i < 4; i++)
      if (i < q_de_a.size() && i < q_in_a.size())
        check_val($sformatf("ramp latency%0d", i), q_de_a[i] - q_in_a[i], 2);
    check_val("ramp frame_done_count", fd_a, 1);
    check_val("ramp frame_done_timing", fd_cyc_a, last_de_a + 1);
    check_val("ramp row_done_count", rd_a, 2);

    // Channel independence on the 4x4 instance
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        send((r == 0 && c == 0) ? 10 : 0, (r == 1 && c == 1) ? 20 : 0,
             (r == 0 && c == 1) ? 30 : 0, 0);
    idle(5);
    check_val("chan px00", res_a[0], 24'h0A141E);
    check_val("chan px01", res_a[1], 24'h000000);
    check_val("chan px11", res_a[3], 24'h000000);

    // ReLU / saturation on the default instance, first pooled row only
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 26; c++)
        send((r == 0 && c == 4) ? 3200 : 0, (c < 6) ? p3_ch1[r * 6 + c] : 0, 0, 0);
    idle(5);
    check_val("relu de_count", de_b, 13);
    check_val("relu row_done_count", rd_b, 1);
    check_val("relu frame_done_count", fd_b, 0);
    check_val("relu sat", res_b[0], 24'h00FF00);
    check_val("relu all_neg", res_b[1], 24'h000000);
    check_val("relu shift", res_b[2], 24'h64D700);
    check_val("relu zero", res_b[3], 24'h000000);

    do_reset();
    feed_b(676, 0);
    idle(5);
    check_frame_b("gapless");

    do_reset();
    feed_b(676, 3);
    idle(5);
    check_frame_b("gapped");

    // Odd size on the 5x5 instance
    do_reset();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        send((r == 4 || c == 4) ? 255 : r * 5 + c, (r == 4 || c == 4) ? 255 : 0, 0, 0);
    idle(5);
    check_val("odd de_count", de_c, 4);
    check_val("odd px00", res_c[0], 24'h060000);
    check_val("odd px01", res_c[1], 24'h080000);
    check_val("odd px10", res_c[2], 24'h100000);
    check_val("odd px11", res_c[3], 24'h120000);
    check_val("odd row_done_count", rd_c, 2);
    check_val("odd frame_done_count", fd_c, 1);

    // Asynchronous reset mid-frame
    do_reset();
    feed_b(40, 0);
    RESET = 1'b0;
    #1;
    check_val("midrst out_de", if_b.out_de, 0);
    check_val("midrst out_data", if_b.out_data, 0);
    check_val("midrst out_addr", if_b.out_addr, 0);
    check_val("midrst out_row", if_b.out_row, 0);
    idle(1);
    RESET = 1'b1;
    clear_mon();
    feed_b(676, 0);
    idle(5);
    check_frame_b("after_reset");

    // frame_start mid-frame, with a poisoned pixel in the same cycle
    do_reset();
    feed_b(40, 0);
    frame_start = 1'b1; in_de = 1'b1;
    ch0 = 21'h0FFFFF; ch1 = 21'h0FFFFF; ch2 = 21'h0FFFFF;
    idle(1);
    frame_start = 1'b0; in_de = 1'b0;
    check_val("fstart out_de", if_b.out_de, 0);
    check_val("fstart row_done", if_b.row_done, 0);
    clear_mon();
    feed_b(676, 0);
    idle(5);
    check_frame_b("after_frame_start");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
